// File: rtl/wb_ram_arbiter.sv
// Two-master Wishbone arbiter that shares the data-RAM slave port between m0 (CPU data) and m1.
// Build option: define WB_ARB_ROUND_ROBIN_EN for round-robin contention; the default build uses fixed m0 priority.
module wb_ram_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o
);

  // state | meaning
  // IDLE  | no owner; slave port parked at 0, stray acks dropped
  // GNT0  | m0 owns the slave port
  // GNT1  | m1 owns the slave port
  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  localparam int unsigned HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  state_t        state, state_nxt;
  logic [HW-1:0] hold_cnt, hold_cnt_nxt, hold_sum;
  logic          own_cyc, own_stb, oth_cyc, own_ack;
  logic          hold_inc, limit_nxt, force_rel;

  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    oth_cyc = 1'b0;
    case (state)
      GNT0: begin
        own_cyc = m0_cyc_i;
        own_stb = m0_stb_i;
        oth_cyc = m1_cyc_i;
      end
      GNT1: begin
        own_cyc = m1_cyc_i;
        own_stb = m1_stb_i;
        oth_cyc = m0_cyc_i;
      end
      default: ;
    endcase
  end

  assign own_ack  = s_ack_i & (state != IDLE);
  assign hold_inc = own_ack & (hold_cnt != HOLD_MAX);
  assign hold_sum = hold_cnt + HW'(hold_inc);
  // Release on the edge that closes the limiting ack, so a streaming owner never sees an extra ack.
  assign limit_nxt = (MAX_HOLD != 0) && (hold_sum == HOLD_MAX);
  assign force_rel = limit_nxt & oth_cyc & ~(own_stb & ~s_ack_i);

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic last_owner;   // 1 = m1 owned last
`endif

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
          state_nxt = last_owner ? GNT0 : GNT1;
`else
          state_nxt = GNT0;
`endif
        end else if (m0_cyc_i) begin
          state_nxt = GNT0;
        end else if (m1_cyc_i) begin
          state_nxt = GNT1;
        end
        hold_cnt_nxt = '0;
      end
      GNT0, GNT1: begin
        hold_cnt_nxt = hold_sum;
        if (!own_cyc || force_rel) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

`ifdef WB_ARB_ROUND_ROBIN_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      last_owner <= 1'b1;
    end else if (state == IDLE && state_nxt == GNT0) begin
      last_owner <= 1'b0;
    end else if (state == IDLE && state_nxt == GNT1) begin
      last_owner <= 1'b1;
    end
  end
`endif

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    case (state)
      GNT0: begin
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i;
        s_we_o  = m0_we_i;
        s_sel_o = m0_sel_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
      end
      GNT1: begin
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i;
        s_we_o  = m1_we_i;
        s_sel_o = m1_sel_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
      end
      default: ;
    endcase
  end

  assign m0_ack_o = s_ack_i & (state == GNT0);
  assign m1_ack_o = s_ack_i & (state == GNT1);
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign grant_o  = {state == GNT1, state == GNT0};

endmodule

// File: doc/wb_ram_arbiter.md
# wb_ram_arbiter

Two-master Wishbone arbiter sharing the single data-RAM slave port (the delayed BRAM wrapper) between the CPU data port (m0) and a second requester (m1: instruction fetch or DMA). Ownership is granted per Wishbone cycle (`cyc`) and registered. An optional hold limit bounds how long one master keeps the RAM while the other waits. Slave-side acknowledge latency is arbitrary; the arbiter never generates acks itself.

## Interface
Parameters:
- `MAX_HOLD`, default 16: max acked transfers per grant while the other master waits; 0 = unlimited.

Ports:
- `wb_clk_i` in 1: clock; single clock domain.
- `wb_rst_i` in 1: reset; synchronous, active-high.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i` in 1 each: master 0 cycle, strobe, write enable.
- `m0_sel_i` in 4: master 0 byte selects.
- `m0_adr_i`, `m0_dat_i` in 32 each: master 0 address and write data.
- `m0_dat_o` out 32: read data to master 0.
- `m0_ack_o` out 1: acknowledge to master 0.
- `m1_*`: same set as `m0_*`, for master 1.
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1 each: slave cycle, strobe, write enable.
- `s_sel_o` out 4: slave byte selects.
- `s_adr_o`, `s_dat_o` out 32 each: slave address and write data.
- `s_dat_i` in 32: slave read data.
- `s_ack_i` in 1: slave acknowledge.
- `grant_o` out 2: one-hot current owner ({m1,m0}); 2'b00 when idle.

## Operation
- FSM states:
  - IDLE: no owner.
  - GNT0: m0 owns the slave.
  - GNT1: m1 owns the slave.
- IDLE:
  - Only one `mX_cyc_i` high → that master is granted at the next edge.
  - Both high → priority rule applies (see Configuration).
  - Neither high → stay in IDLE.
- GNTx:
  - Owner `cyc` low → go to IDLE. Every handover passes through IDLE, giving one dead cycle with `s_cyc_o`=0 between owners.
  - Hold limit reached and the other master's `cyc` high → forced release to IDLE.
- Slave mux, combinational from the state register:
  - GNTx: `s_cyc_o`=`mX_cyc_i`, `s_stb_o`=`mX_stb_i`, and `we`/`sel`/`adr`/`dat` come from mX.
  - IDLE: all `s_*` outputs are 0.
- Ack routing:
  - `mX_ack_o` = `s_ack_i` & (state==GNTx).
  - The non-owner sees ack 0.
  - `s_ack_i` in IDLE is ignored.
- Read data: `m0_dat_o` = `m1_dat_o` = `s_dat_i` unconditionally. Only ack qualifies the data.
- Hold counter:
  - Cleared on entry to any GNT state.
  - Increments on each owner ack and saturates at `MAX_HOLD`.
  - Width is $clog2(`MAX_HOLD`+1), minimum 1 bit.
  - Limit reached = (`MAX_HOLD`≠0) & (count==`MAX_HOLD`).
- Forced release:
  - Takes effect at the edge after the ack that brings count to `MAX_HOLD`, provided the other `cyc` is high at that edge.
  - Evaluated only on cycles with no owner `stb`+ack pending, i.e. never mid-transfer: the ack completes the transfer before the state changes.
  - The preempted master keeps `cyc` high, sees no acks, and re-arbitrates from IDLE.
- Reset:
  - State IDLE, all `s_*` outputs 0, `m0_ack_o`=`m1_ack_o`=0, `grant_o`=0, hold counter 0, last-owner register = m1.
  - Reset mid-transfer drops `s_cyc_o` on the next cycle. Any late `s_ack_i` is ignored.

## Timing
- Grant latency: 1 cycle. `cyc` rises in IDLE at cycle N → `s_cyc_o`/`s_stb_o` valid in cycle N+1.
- Transfer latency = slave ack latency; the arbiter adds no cycles once granted. Ack is combinational pass-through.
- Release: owner `cyc` falls at cycle N → IDLE at N+1 → next owner on the slave at N+2.
- Simultaneous owner `cyc` drop and other `cyc` rise: normal IDLE path, no special case.
- Back-to-back transfers with `cyc` held: no bubbles while granted.

## Configuration
- `WB_ARB_ROUND_ROBIN_EN` defined:
  - Both request in IDLE → grant the master that is not the last-owner register.
  - Last-owner updates on every grant.
  - After reset, m0 wins the first contention.
- Not defined:
  - Fixed priority: m0 always wins contention in IDLE.
  - The last-owner register is not built.
  - The hold limit still applies.

## Test plan
- Single master: m0 reads 0x100 with the slave acking 3 cycles after `stb` → `s_adr_o`=0x100 from cycle 1, `m0_ack_o` pulses once, `m1_ack_o` stays 0, `grant_o`=01.
- Contention, round-robin build: m0 and m1 both raise `cyc` for one transfer each, repeated 3 times → grants m0,m1,m0,m1,m0,m1, each separated by one IDLE cycle.
- Contention, fixed build: same stimulus with m0 re-requesting immediately → m1 granted only when m0's `cyc` is low in IDLE.
- Hold limit: `MAX_HOLD`=4, m0 streams 10 transfers while m1 waits → m0 gets 4 acks, IDLE, m1 served, then m0 resumes. No ack is lost or duplicated.
- Reset mid-transfer: assert `wb_rst_i` while GNT1 with `stb` high and ack pending → next cycle `s_cyc_o`=0, `grant_o`=00. A subsequent `s_ack_i` produces no master ack.
- Stray ack: `s_ack_i`=1 in IDLE → `m0_ack_o`=`m1_ack_o`=0, state unchanged.
